// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the streaming ones-counter.
package popcount_pkg;

  typedef enum logic {
    POPCNT_WORD  = 1'b0,
    POPCNT_FRAME = 1'b1
  } popcnt_mode_e;

  // Bits needed to hold a ones count of a w-bit word, including the all-ones case.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/popcount_stream_if.sv
// Valid/ready stream bundle between a beat source, the ones-counter and its result sink.
interface popcount_stream_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 32
) ();
  import popcount_pkg::*;

  popcnt_mode_e            mode;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_WIDTH-1:0]    out_count;
  logic                    out_last;
  logic                    out_sat;

  modport master (
    output mode, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_count, out_last, out_sat
  );

  modport slave (
    input  mode, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_count, out_last, out_sat
  );

endinterface

// File: rtl/popcount_chunk.sv
// Combinational ones count of a single CHUNK_WIDTH-bit slice.
module popcount_chunk
  import popcount_pkg::*;
#(
  parameter int unsigned CHUNK_WIDTH = 8,
  localparam int unsigned CW = cnt_width(CHUNK_WIDTH)
) (
  input  logic [CHUNK_WIDTH-1:0] chunk,
  output logic [CW-1:0]          count_c
);

  always_comb begin
    count_c = '0;
    for (int unsigned i = 0; i < CHUNK_WIDTH; i++) begin
      count_c = count_c + CW'(chunk[i]);
    end
  end

endmodule

// File: rtl/popcount_stream.sv
// Two-stage pipelined ones-counter: per-word counts or saturating per-frame totals.
module popcount_stream
  import popcount_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned CHUNK_WIDTH = 8,
  parameter int unsigned ACC_WIDTH   = 32
) (
  input logic              clk,
  input logic              rst,
  popcount_stream_if.slave bus
);

  localparam int unsigned NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int unsigned CNT_W      = cnt_width(DATA_WIDTH);
  localparam int unsigned CHK_W      = cnt_width(CHUNK_WIDTH);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

  if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_chunk
    $error("popcount_stream: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
  end
  if (ACC_WIDTH < CNT_W) begin : g_bad_acc
    $error("popcount_stream: ACC_WIDTH too narrow for a full-word count");
  end

  logic                  en_c;
  logic                  accept_c;
  popcnt_mode_e          eff_mode_c;

  popcnt_mode_e          mode_q;
  logic                  in_frame_q;

  logic [CHK_W-1:0]      chunk_cnt_c [NUM_CHUNKS];
  logic [CHK_W-1:0]      s1_cnt_q    [NUM_CHUNKS];
  logic                  s1_valid_q;
  logic                  s1_last_q;
  logic                  s1_frame_q;

  logic [CNT_W-1:0]      sum_c;
  logic [ACC_WIDTH:0]    acc_sum_c;
  logic                  overflow_c;
  logic [ACC_WIDTH-1:0]  acc_next_c;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic                  sat_q;

  logic                  out_valid_q;
  logic [ACC_WIDTH-1:0]  out_count_q;
  logic                  out_last_q;
  logic                  out_sat_q;

  // The whole pipeline freezes only while a result is waiting to be taken.
  assign en_c       = !(out_valid_q && !bus.out_ready);
  assign accept_c   = bus.in_valid && en_c;
  assign eff_mode_c = in_frame_q ? mode_q : bus.mode;

  // Mode is captured on the first beat of a frame and held until its last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= POPCNT_WORD;
      in_frame_q <= 1'b0;
    end else if (accept_c) begin
      if (!in_frame_q) begin
        mode_q <= bus.mode;
      end
      in_frame_q <= !bus.in_last;
    end
  end

  for (genvar g = 0; g < NUM_CHUNKS; g++) begin : g_chunk
    popcount_chunk #(
      .CHUNK_WIDTH (CHUNK_WIDTH)
    ) u_chunk (
      .chunk   (bus.in_data[g*CHUNK_WIDTH +: CHUNK_WIDTH]),
      .count_c (chunk_cnt_c[g])
    );
  end

  // Stage 1: per-chunk counts plus beat attributes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_cnt_q   <= '{default: '0};
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_frame_q <= 1'b0;
    end else if (en_c) begin
      s1_cnt_q   <= chunk_cnt_c;
      s1_valid_q <= accept_c;
      s1_last_q  <= bus.in_last;
      s1_frame_q <= (eff_mode_c == POPCNT_FRAME);
    end
  end

  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
      sum_c = sum_c + CNT_W'(s1_cnt_q[i]);
    end
  end

  // One spare bit on the add exposes overflow; clamp to the top code when it fires.
  assign acc_sum_c  = {1'b0, acc_q} + (ACC_WIDTH+1)'(sum_c);
  assign overflow_c = acc_sum_c[ACC_WIDTH];
  assign acc_next_c = overflow_c ? ACC_MAX : acc_sum_c[ACC_WIDTH-1:0];

  // Stage 2: word result, frame accumulation, or frame result with accumulator clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
    end else if (en_c) begin
      out_valid_q <= 1'b0;
      if (s1_valid_q) begin
        if (!s1_frame_q) begin
          out_valid_q <= 1'b1;
          out_count_q <= ACC_WIDTH'(sum_c);
          out_last_q  <= s1_last_q;
          out_sat_q   <= 1'b0;
        end else if (s1_last_q) begin
          out_valid_q <= 1'b1;
          out_count_q <= acc_next_c;
          out_last_q  <= 1'b1;
          out_sat_q   <= sat_q | overflow_c;
          acc_q       <= '0;
          sat_q       <= 1'b0;
        end else begin
          acc_q <= acc_next_c;
          sat_q <= sat_q | overflow_c;
        end
      end
    end
  end

  assign bus.in_ready  = en_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_count = out_count_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_popcount_stream.sv
// Bench for popcount_stream: directed tables, corner sequences and a random stream vs a frame-level model.
module tb_popcount_stream;
  import popcount_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  popcount_stream_if #(.DATA_WIDTH(16), .ACC_WIDTH(32)) bus  ();
  popcount_stream_if #(.DATA_WIDTH(16), .ACC_WIDTH(5))  bus5 ();

  // The narrow-accumulator copy sees the identical stream and back-pressure.
  assign bus5.mode      = bus.mode;
  assign bus5.in_valid  = bus.in_valid;
  assign bus5.in_data   = bus.in_data;
  assign bus5.in_last   = bus.in_last;
  assign bus5.out_ready = bus.out_ready;

  popcount_stream #(.DATA_WIDTH(16), .CHUNK_WIDTH(8), .ACC_WIDTH(32)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  popcount_stream #(.DATA_WIDTH(16), .CHUNK_WIDTH(8), .ACC_WIDTH(5)) dut5 (
    .clk (clk), .rst (rst), .bus (bus5)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: expected results queued per accepted beat.
  typedef struct {
    longint c32;
    longint c5;
    bit     last;
    bit     s32;
    bit     s5;
  } exp_t;

  exp_t         expq[$];
  bit           m_in_frame;
  popcnt_mode_e m_mode;
  longint       m_acc32, m_acc5;
  bit           m_sat32, m_sat5;

  int     n_out = 0;
  longint last_c32, last_c5;
  bit     last_l, last_s32, last_s5;
  bit     held;
  longint h_cnt;
  bit     h_last, h_sat;

  function automatic void model_reset();
    m_in_frame = 0; m_mode = POPCNT_WORD;
    m_acc32 = 0; m_acc5 = 0; m_sat32 = 0; m_sat5 = 0;
    expq.delete();
  endfunction

  function automatic void model_accept(popcnt_mode_e md_in, logic [15:0] d, logic l);
    popcnt_mode_e md;
    int n;
    exp_t e;
    md = m_in_frame ? m_mode : md_in;
    if (!m_in_frame) m_mode = md_in;
    m_in_frame = !l;
    n = $countones(d);
    if (md == POPCNT_WORD) begin
      e = '{c32: n, c5: n, last: l, s32: 0, s5: 0};
      expq.push_back(e);
    end else begin
      m_acc32 = m_acc32 + n;
      if (m_acc32 > 64'hFFFF_FFFF) begin m_acc32 = 64'hFFFF_FFFF; m_sat32 = 1; end
      m_acc5 = m_acc5 + n;
      if (m_acc5 > 31) begin m_acc5 = 31; m_sat5 = 1; end
      if (l) begin
        e = '{c32: m_acc32, c5: m_acc5, last: 1, s32: m_sat32, s5: m_sat5};
        expq.push_back(e);
        m_acc32 = 0; m_acc5 = 0; m_sat32 = 0; m_sat5 = 0;
      end
    end
  endfunction

  // Monitor + model, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      model_reset();
      held = 0;
    end else begin
      if (held) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_count", bus.out_count, h_cnt);
        check("hold_last",  bus.out_last,  h_last);
        check("hold_sat",   bus.out_sat,   h_sat);
      end
      held   = bus.out_valid && !bus.out_ready;
      h_cnt  = bus.out_count;
      h_last = bus.out_last;
      h_sat  = bus.out_sat;
      if (bus.out_valid || bus5.out_valid)
        check("valid_narrow_copy", bus5.out_valid, bus.out_valid);
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got count %0d, expected no output", bus.out_count);
        end else begin
          e = expq.pop_front();
          check("count32", bus.out_count,  e.c32);
          check("last32",  bus.out_last,   e.last);
          check("sat32",   bus.out_sat,    e.s32);
          check("count5",  bus5.out_count, e.c5);
          check("last5",   bus5.out_last,  e.last);
          check("sat5",    bus5.out_sat,   e.s5);
        end
        n_out++;
        last_c32 = bus.out_count; last_c5 = bus5.out_count;
        last_l = bus.out_last; last_s32 = bus.out_sat; last_s5 = bus5.out_sat;
      end
      if (bus.in_valid && bus.in_ready)
        model_accept(bus.mode, bus.in_data, bus.in_last);
    end
  end

  task automatic send_beat(input popcnt_mode_e m, input logic [15:0] d, input logic l);
    bit ok = 0;
    @(posedge clk); #1;
    bus.mode = m; bus.in_data = d; bus.in_last = l; bus.in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready 0 for 100 cycles, expected 1");
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (5) @(posedge clk);
  endtask

  typedef struct {
    popcnt_mode_e mode;
    logic [15:0]  data;
    logic         last;
    bit           exp_valid;
    int           exp_count;
    bit           exp_last;
    bit           exp_sat;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int stall_seen;
    bit done;

    tbl[0] = '{POPCNT_WORD,  16'h0000, 1'b1, 1'b1, 0,  1'b1, 1'b0};
    tbl[1] = '{POPCNT_WORD,  16'hFFFF, 1'b0, 1'b1, 16, 1'b0, 1'b0};
    tbl[2] = '{POPCNT_WORD,  16'h8001, 1'b1, 1'b1, 2,  1'b1, 1'b0};
    tbl[3] = '{POPCNT_WORD,  16'h00F0, 1'b1, 1'b1, 4,  1'b1, 1'b0};
    tbl[4] = '{POPCNT_FRAME, 16'hFFFF, 1'b0, 1'b0, 0,  1'b0, 1'b0};
    tbl[5] = '{POPCNT_FRAME, 16'h0F0F, 1'b0, 1'b0, 0,  1'b0, 1'b0};
    tbl[6] = '{POPCNT_FRAME, 16'h0001, 1'b1, 1'b1, 25, 1'b1, 1'b0};

    rst = 1'b1;
    bus.mode = POPCNT_WORD; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.in_last = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_count", bus.out_count, 0);
    check("reset_out_last",  bus.out_last,  0);
    check("reset_out_sat",   bus.out_sat,   0);
    check("reset_in_ready",  bus.in_ready,  1);

    // Back-to-back WORD beats then a 3-beat FRAME; each result 2 clks after accept.
    for (int j = 0; j < 9; j++) begin
      @(posedge clk); #1;
      if (j < 7) begin
        bus.mode = tbl[j].mode; bus.in_data = tbl[j].data;
        bus.in_last = tbl[j].last; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (j >= 2) begin
        check($sformatf("tbl_valid[%0d]", j-2), bus.out_valid, tbl[j-2].exp_valid);
        if (tbl[j-2].exp_valid) begin
          check($sformatf("tbl_count[%0d]", j-2), bus.out_count, tbl[j-2].exp_count);
          check($sformatf("tbl_last[%0d]", j-2),  bus.out_last,  tbl[j-2].exp_last);
          check($sformatf("tbl_sat[%0d]", j-2),   bus.out_sat,   tbl[j-2].exp_sat);
        end
      end
    end
    settle();

    // Backpressure: 6 WORD beats against a 5-clk out_ready stall.
    n0 = n_out; stall_seen = 0;
    fork
      begin
        @(posedge clk); #1 bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 6; i++) send_beat(POPCNT_WORD, 16'($urandom), 1'b1);
        idle();
      end
      begin
        repeat (12) begin
          @(negedge clk);
          if (!bus.in_ready) stall_seen++;
        end
      end
    join
    settle();
    check("bp_delivered", n_out - n0, 6);
    check("bp_in_ready_dropped", (stall_seen > 0) ? 1 : 0, 1);

    // Saturation on the 5-bit accumulator, then a clean frame.
    for (int i = 0; i < 3; i++) send_beat(POPCNT_FRAME, 16'hFFFF, (i == 2) ? 1'b1 : 1'b0);
    idle(); settle();
    check("sat_count5", last_c5, 31);
    check("sat_flag5",  last_s5, 1);
    check("sat_count32", last_c32, 48);
    check("sat_flag32",  last_s32, 0);
    send_beat(POPCNT_FRAME, 16'h0003, 1'b1);
    idle(); settle();
    check("post_sat_count5", last_c5, 2);
    check("post_sat_flag5",  last_s5, 0);

    // Reset in the middle of a frame discards the partial sum.
    n0 = n_out;
    send_beat(POPCNT_FRAME, 16'hFFFF, 1'b0);
    send_beat(POPCNT_FRAME, 16'hFFFF, 1'b0);
    idle();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    send_beat(POPCNT_FRAME, 16'h0007, 1'b1);
    idle(); settle();
    check("rst_mid_outputs", n_out - n0, 1);
    check("rst_mid_count", last_c32, 3);

    // Mode change mid-frame is ignored until the next frame.
    n0 = n_out;
    send_beat(POPCNT_FRAME, 16'h00FF, 1'b0);
    send_beat(POPCNT_WORD,  16'h000F, 1'b0);
    send_beat(POPCNT_WORD,  16'h0003, 1'b1);
    idle(); settle();
    check("midmode_outputs", n_out - n0, 1);
    check("midmode_count", last_c32, 14);
    check("midmode_last", last_l, 1);
    send_beat(POPCNT_WORD, 16'h0101, 1'b0);
    idle(); settle();
    check("nextmode_outputs", n_out - n0, 2);
    check("nextmode_count", last_c32, 2);
    check("nextmode_last", last_l, 0);
    send_beat(POPCNT_WORD, 16'h0011, 1'b1);
    idle(); settle();
    check("nextmode_close_count", last_c32, 2);

    // Random stream with random gaps and back-pressure.
    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(4) == 0) idle();
          send_beat(popcnt_mode_e'($urandom_range(1)), 16'($urandom),
                    ($urandom_range(3) == 0) ? 1'b1 : 1'b0);
        end
        idle();
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1 bus.out_ready = ($urandom_range(3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    check("random_all_delivered", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
